// File: rtl/vmc_change_sequencer.sv
// Coin-change payout sequencer: greedy 10/5/2/1 Rs hopper selection over an eject/ack handshake.
// Optional ack-timeout jam detection is compiled in with `define VMC_ACK_TIMEOUT_EN.
module vmc_change_sequencer #(
  parameter int AMT_W       = 6,
  parameter int CNT_W       = 8,
  parameter int INIT_CNT    = 20,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic             eject_ack,
  output logic [3:0]       eject,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [3:0]       empty,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    EJECT,
    DONE
  } state_t;

  // Hopper index 3..0 maps to 10, 5, 2, 1 Rs, matching the eject/empty bit order.
  function automatic logic [AMT_W-1:0] den(input logic [1:0] idx);
    case (idx)
      2'd3:    den = AMT_W'(10);
      2'd2:    den = AMT_W'(5);
      2'd1:    den = AMT_W'(2);
      default: den = AMT_W'(1);
    endcase
  endfunction

  state_t           state, state_n;
  logic [1:0]       sel, sel_n;
  logic [CNT_W-1:0] cnt   [4];
  logic [CNT_W-1:0] cnt_n [4];
  logic [AMT_W-1:0] rem_n;
  logic [3:0]       eject_n;
  logic [3:0]       empty_n;
  logic             short_n;
  logic             fault_n;
  logic             found;
  logic [1:0]       pick;

`ifdef VMC_ACK_TIMEOUT_EN
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;
  logic             timeout;

  assign timeout = (tmr == TMR_W'(ACK_TIMEOUT - 1));

  // Counts completed EJECT cycles; restarts whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (state != EJECT) begin
      tmr <= '0;
    end else if (!timeout) begin
      tmr <= tmr + TMR_W'(1);
    end
  end
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    rem_n   = remaining;
    eject_n = eject;
    short_n = short;
    fault_n = fault;
    found   = 1'b0;
    pick    = 2'd0;

    // Ascending scan: the last eligible hopper seen is the largest denomination.
    for (int i = 0; i < 4; i++) begin
      if (cnt[i] != '0 && den(2'(i)) <= remaining) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end

    unique case (state)
      IDLE: begin
        if (refill) begin
          for (int i = 0; i < 4; i++) cnt_n[i] = CNT_W'(INIT_CNT);
          fault_n = 1'b0;
        end
        if (start) begin
          rem_n   = amount;
          short_n = 1'b0;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (remaining == '0) begin
          short_n = 1'b0;
          state_n = DONE;
        end else if (found) begin
          sel_n   = pick;
          eject_n = 4'b0001 << pick;
          state_n = EJECT;
        end else begin
          short_n = 1'b1;
          state_n = DONE;
        end
      end
      EJECT: begin
        if (eject_ack) begin
          rem_n      = remaining - den(sel);
          cnt_n[sel] = cnt[sel] - CNT_W'(1);
          eject_n    = 4'b0000;
          state_n    = SELECT;
        end
`ifdef VMC_ACK_TIMEOUT_EN
        else if (timeout) begin
          // A jammed hopper is written off so the retry falls back to smaller coins.
          cnt_n[sel] = '0;
          eject_n    = 4'b0000;
          fault_n    = 1'b1;
          state_n    = SELECT;
        end
`endif
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    for (int i = 0; i < 4; i++) empty_n[i] = (cnt_n[i] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      // NOTE: the four counters are live state, not storage, so they are reset like any other register.
      for (int i = 0; i < 4; i++) cnt[i] <= CNT_W'(INIT_CNT);
      remaining <= '0;
      eject     <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      empty     <= 4'b0000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      remaining <= rem_n;
      eject     <= eject_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      short     <= short_n;
      empty     <= empty_n;
    end
  end

`ifdef VMC_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault <= 1'b0;
    else     fault <= fault_n;
  end
`else
  assign fault = 1'b0;
`endif

endmodule
